// File: rtl/eeprom_spi_reader.sv
// eeprom_spi_reader: SPI mode-0 master that issues a READ (0x03) command and an address
// to one of four EEPROMs, then streams len bytes back. Every output is registered.
module eeprom_spi_reader #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        dev,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic              abort,
  input  logic              SDIN,
  output logic              CSf,
  output logic              SCLKf,
  output logic              SDOUTf,
  output logic [1:0]        sel_f,
  output logic              busy,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              done
);

  localparam int         TX_W      = 8 + ADDR_W;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);
  localparam logic [7:0] READ_CMD  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DATA,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              csf_q, csf_d;
  logic              sclk_q, sclk_d;
  logic              sdout_q, sdout_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic              div_last;

  // The half-period divider wraps on this cycle; every SCLKf edge and phase change keys off it.
  assign div_last = (div_cnt_q == DIV_LAST);

  // Next-state logic for the transfer sequencer, the SCLKf generator and the shift registers.
  always_comb begin
    state_d    = state_q;
    csf_d      = csf_q;
    sclk_d     = sclk_q;
    sdout_d    = sdout_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;

    case (state_q)
      IDLE: begin
        if (start && (len != 8'd0)) begin
          state_d    = SETUP;
          busy_d     = 1'b1;
          csf_d      = 1'b0;
          sel_d      = dev;
          tx_d       = {READ_CMD, addr};
          byte_cnt_d = len;
          div_cnt_d  = 8'd0;
          bit_cnt_d  = 5'd0;
          sclk_d     = 1'b0;
          sdout_d    = 1'b0;
        end
      end

      SETUP, CMD, ADDR, DATA: begin
        if (abort) begin
          // Abort parks SCLKf low at once and lets HOLD close the frame cleanly.
          state_d   = HOLD;
          sclk_d    = 1'b0;
          sdout_d   = 1'b0;
          div_cnt_d = 8'd0;
          bit_cnt_d = 5'd0;
        end else if (!div_last) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else if (state_q == SETUP) begin
          state_d   = CMD;
          div_cnt_d = 8'd0;
          sdout_d   = tx_q[TX_W-1];
        end else if (!sclk_q) begin
          // Rising SCLKf edge: this is the instant SDIN is sampled.
          sclk_d    = 1'b1;
          div_cnt_d = 8'd0;
          if (state_q == DATA) begin
            rx_d = {rx_q[5:0], SDIN};
            if (bit_cnt_q == 5'd7) begin
              rd_data_d  = {rx_q, SDIN};
              rd_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q - 8'd1;
            end
          end
        end else begin
          // Falling SCLKf edge: the bit is complete, so present the next one.
          sclk_d    = 1'b0;
          div_cnt_d = 8'd0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == CMD) begin
            tx_d    = tx_q << 1;
            sdout_d = tx_q[TX_W-2];
            if (bit_cnt_q == 5'd7) begin
              state_d   = ADDR;
              bit_cnt_d = 5'd0;
            end
          end else if (state_q == ADDR) begin
            tx_d = tx_q << 1;
            if (bit_cnt_q == ADDR_LAST) begin
              state_d   = DATA;
              bit_cnt_d = 5'd0;
              sdout_d   = 1'b0;
            end else begin
              sdout_d = tx_q[TX_W-2];
            end
          end else begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (byte_cnt_q == 8'd0) begin
                state_d = HOLD;
              end
            end
          end
        end
      end

      HOLD: begin
        if (div_last) begin
          state_d    = IDLE;
          csf_d      = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          div_cnt_d  = 8'd0;
          bit_cnt_d  = 5'd0;
          byte_cnt_d = 8'd0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset deselects the EEPROM asynchronously and never emits done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      csf_q      <= 1'b1;
      sclk_q     <= 1'b0;
      sdout_q    <= 1'b0;
      sel_q      <= 2'd0;
      busy_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 5'd0;
      byte_cnt_q <= 8'd0;
      tx_q       <= '0;
      rx_q       <= 7'd0;
    end else begin
      state_q    <= state_d;
      csf_q      <= csf_d;
      sclk_q     <= sclk_d;
      sdout_q    <= sdout_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
    end
  end

  assign CSf      = csf_q;
  assign SCLKf    = sclk_q;
  assign SDOUTf   = sdout_q;
  assign sel_f    = sel_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_eeprom_spi_reader.sv
// Testbench for eeprom_spi_reader: an EEPROM model answers the reads from a random memory
// image, and every observation is compared with values derived from the read rules.
module tb_eeprom_spi_reader;

  localparam int AW   = 16;
  localparam int DIV  = 4;
  localparam int DIV2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    dev = 2'd0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    len = 8'd0;
  logic          sdin = 1'b0;
  logic          csf, sclk, sdout, busy, rd_valid, done;
  logic [1:0]    sel;
  logic [7:0]    rd_data;

  logic          start2 = 1'b0;
  logic [1:0]    dev2 = 2'd0;
  logic [AW-1:0] addr2 = '0;
  logic [7:0]    len2 = 8'd0;
  logic          abort2 = 1'b0;
  logic          sdin2 = 1'b0;
  logic          csf2, sclk2, sdout2, busy2, rd_valid2, done2;
  logic [1:0]    sel2;
  logic [7:0]    rd_data2;

  eeprom_spi_reader #(.CLK_DIV(DIV), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dev(dev), .addr(addr), .len(len),
    .abort(abort), .SDIN(sdin), .CSf(csf), .SCLKf(sclk), .SDOUTf(sdout), .sel_f(sel),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
  );

  eeprom_spi_reader #(.CLK_DIV(DIV2), .ADDR_W(AW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dev(dev2), .addr(addr2), .len(len2),
    .abort(abort2), .SDIN(sdin2), .CSf(csf2), .SCLKf(sclk2), .SDOUTf(sdout2), .sel_f(sel2),
    .busy(busy2), .rd_data(rd_data2), .rd_valid(rd_valid2), .done(done2)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem [4][256];

  int cyc = 0;
  logic p_sclk = 1'b0, p_csf = 1'b1, p_sdout = 1'b0;
  logic [1:0] p_sel = 2'd0;
  int rise_total = 0, rise_in_frame = 0, fall_in_frame = 0;
  int rv_total = 0, done_total = 0, sel_err = 0, mode_err = 0, period_err = 0;
  int csf_low_total = 0, busy_total = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0;
  int last_fall_cyc = 0, done_cyc = 0;
  logic [23:0] mosi_word = '0;
  logic [7:0] got_log [512];
  int idx1;
  logic [7:0] b1;

  // Main bus monitor plus the EEPROM model: samples on the falling clk edge, records edge
  // timing, collects the command/address stream and shifts out memory bits after SCLKf falls.
  always @(negedge clk) begin
    cyc++;
    if (!csf && p_csf) begin
      cs_fall_cyc = cyc;
      rise_in_frame = 0;
      fall_in_frame = 0;
      mosi_word = '0;
    end
    if (csf && !p_csf) cs_rise_cyc = cyc;
    if (!csf) begin
      csf_low_total++;
      if (!p_csf && (sel !== p_sel)) sel_err++;
      if (sclk && !p_sclk) begin
        if (rise_in_frame == 0) first_rise_cyc = cyc;
        else if (cyc - last_rise_cyc != 2 * DIV) period_err++;
        last_rise_cyc = cyc;
        rise_in_frame++;
        rise_total++;
        if (rise_in_frame <= 24) mosi_word = {mosi_word[22:0], sdout};
      end
      if (!sclk && p_sclk) begin
        last_fall_cyc = cyc;
        fall_in_frame++;
        if (fall_in_frame >= 24) begin
          idx1 = fall_in_frame - 24;
          b1 = mem[sel][(int'(mosi_word[7:0]) + idx1 / 8) % 256];
          sdin = b1[7 - (idx1 % 8)];
        end
      end
    end
    if (sclk && csf) mode_err++;
    if (sclk && p_sclk && (sdout !== p_sdout)) mode_err++;
    if (busy) busy_total++;
    if (rd_valid) begin
      got_log[rv_total % 512] = rd_data;
      rv_total++;
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    p_sclk = sclk;
    p_csf = csf;
    p_sdout = sdout;
    p_sel = sel;
  end

  int cyc2 = 0, rise2_total = 0, rise2_frame = 0, fall2 = 0, last_rise2 = 0;
  int period_err2 = 0, rv2_total = 0, done2_total = 0;
  logic p_sclk2 = 1'b0, p_csf2 = 1'b1;
  logic [7:0] got2 = 8'h00;
  logic [7:0] pat2 = 8'h96;

  // Second instance monitor (fast divider): checks the SCLKf period and feeds a fixed byte.
  always @(negedge clk) begin
    cyc2++;
    if (!csf2 && p_csf2) begin
      rise2_frame = 0;
      fall2 = 0;
    end
    if (!csf2 && sclk2 && !p_sclk2) begin
      if (rise2_frame > 0 && (cyc2 - last_rise2 != 2 * DIV2)) period_err2++;
      last_rise2 = cyc2;
      rise2_frame++;
      rise2_total++;
    end
    if (!csf2 && !sclk2 && p_sclk2) begin
      fall2++;
      if (fall2 >= 24 && fall2 < 32) sdin2 = pat2[31 - fall2];
    end
    if (rd_valid2) begin
      got2 = rd_data2;
      rv2_total++;
    end
    if (done2) done2_total++;
    p_sclk2 = sclk2;
    p_csf2 = csf2;
  end

  // Advance to just after the next falling clk edge, where outputs are stable.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Compare one observation and account for it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a one-cycle start request, optionally with abort raised in the same cycle.
  task automatic applyStimulus(input logic [1:0] d, input logic [AW-1:0] a,
                               input logic [7:0] n, input bit with_abort);
    start = 1'b1;
    dev = d;
    addr = a;
    len = n;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    len = 8'd0;
    dev = 2'd0;
  endtask

  // Full read transaction checked against the memory image and the frame timing rules.
  task automatic runRead(input logic [1:0] d, input logic [AW-1:0] a, input logic [7:0] n,
                         input bit interfere, input bit with_abort);
    int b_rise, b_rv, b_done, k;
    b_rise = rise_total;
    b_rv = rv_total;
    b_done = done_total;
    applyStimulus(d, a, n, with_abort);
    checkOutput("busy_after_start", {busy, csf}, 2'b10);
    checkOutput("sel_after_start", sel, d);
    if (interfere) begin
      k = 0;
      while (rise_in_frame < 14 && k < 500) begin
        tick();
        k++;
      end
      start = 1'b1;
      dev = 2'd1;
      len = 8'd5;
      tick();
      start = 1'b0;
      dev = 2'd0;
      len = 8'd0;
      checkOutput("sel_during_busy_start", sel, d);
    end
    k = 0;
    while (done_total == b_done && k < 3000) begin
      tick();
      k++;
    end
    repeat (3) tick();
    checkOutput("done_pulses", done_total - b_done, 1);
    checkOutput("sclk_rises", rise_total - b_rise, 24 + 8 * int'(n));
    checkOutput("rd_valid_count", rv_total - b_rv, n);
    for (int i = 0; i < int'(n); i++)
      checkOutput("data_byte", got_log[(b_rv + i) % 512], mem[d][(int'(a) + i) % 256]);
    checkOutput("cmd_addr_stream", mosi_word, {8'h03, a});
    checkOutput("setup_gap", first_rise_cyc - cs_fall_cyc, 2 * DIV);
    checkOutput("hold_gap", cs_rise_cyc - last_fall_cyc, DIV);
    checkOutput("done_with_cs_rise", done_cyc, cs_rise_cyc);
    checkOutput("idle_after_done", {busy, csf, sclk}, 3'b010);
    checkOutput("sel_held", sel, d);
  endtask

  initial begin
    int b_rv, b_done, b_low, b_busy, k;
    for (int d = 0; d < 4; d++)
      for (int a = 0; a < 256; a++)
        mem[d][a] = 8'($urandom);
    mem[2][8'h34] = 8'hA5;
    mem[2][8'h35] = 8'h3C;
    mem[2][8'h36] = 8'hFF;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", {csf, sclk, sdout, sel, busy, rd_data, rd_valid, done},
                {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0});
    checkOutput("reset_outputs2", {csf2, sclk2, sdout2, sel2, busy2, rd_data2, rd_valid2, done2},
                {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0});
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] basic read");
    runRead(2'd2, 16'h1234, 8'd3, 1'b0, 1'b0);

    $display("[TB] start while busy");
    runRead(2'd2, 16'h1234, 8'd3, 1'b1, 1'b0);

    $display("[TB] abort during address phase");
    b_rv = rv_total;
    b_done = done_total;
    applyStimulus(2'd0, 16'($urandom), 8'd2, 1'b0);
    k = 0;
    while (rise_in_frame < 19 && k < 500) begin
      tick();
      k++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_sclk_low", sclk, 1'b0);
    k = 1;
    while (csf !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    checkOutput("abort_cs_delay", k, DIV + 1);
    checkOutput("abort_done_with_cs", {done, busy}, 2'b10);
    repeat (4) tick();
    checkOutput("abort_done_once", done_total - b_done, 1);
    checkOutput("abort_no_rd_valid", rv_total - b_rv, 0);

    $display("[TB] len zero and idle abort");
    b_done = done_total;
    b_low = csf_low_total;
    b_busy = busy_total;
    start = 1'b1;
    len = 8'd0;
    dev = 2'd3;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (20) tick();
    checkOutput("len0_cs_quiet", csf_low_total - b_low, 0);
    checkOutput("len0_busy_quiet", busy_total - b_busy, 0);
    checkOutput("len0_no_done", done_total - b_done, 0);

    $display("[TB] start with simultaneous abort");
    runRead(2'($urandom), 16'($urandom), 8'd2, 1'b0, 1'b1);

    $display("[TB] reset mid transfer");
    b_done = done_total;
    applyStimulus(2'd3, 16'($urandom), 8'd3, 1'b0);
    k = 0;
    while (rise_in_frame < 30 && k < 1000) begin
      tick();
      k++;
    end
    checkOutput("reset_reached_data", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", {csf, busy, sclk}, 3'b100);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("reset_no_done", done_total - b_done, 0);
    runRead(2'($urandom), 16'($urandom), 8'($urandom_range(1, 4)), 1'b0, 1'b0);

    $display("[TB] random reads");
    for (int t = 0; t < 5; t++)
      runRead(2'($urandom), 16'($urandom), 8'($urandom_range(1, 4)), 1'b0, 1'b0);

    $display("[TB] fast divider");
    start2 = 1'b1;
    dev2 = 2'd1;
    addr2 = 16'($urandom);
    len2 = 8'd1;
    tick();
    start2 = 1'b0;
    len2 = 8'd0;
    checkOutput("fast_sel", sel2, 2'd1);
    k = 0;
    while (done2_total == 0 && k < 1000) begin
      tick();
      k++;
    end
    repeat (3) tick();
    checkOutput("fast_rises", rise2_total, 32);
    checkOutput("fast_period", period_err2, 0);
    checkOutput("fast_byte", got2, 8'h96);
    checkOutput("fast_rd_valid", rv2_total, 1);
    checkOutput("fast_done", {done2_total[7:0], busy2, csf2}, {8'd1, 1'b0, 1'b1});

    checkOutput("sel_stability", sel_err, 0);
    checkOutput("spi_mode0", mode_err, 0);
    checkOutput("sclk_period", period_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/eeprom_spi_reader.md
EEPROM_SPI_READER -- requirements
Module: eeprom_spi_reader

Interface
REQ-001 SHALL have parameter: CLK_DIV, 4, clk cycles per SCLK half-period (legal values 2..255).
REQ-002 SHALL have parameter: ADDR_W, 16, EEPROM address width in bits (8, 16 or 24).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  request strobe, one cycle.
REQ-006 SHALL have port: dev  input  2  target EEPROM index 0..3, sampled on accepted start.
REQ-007 SHALL have port: addr  input  ADDR_W  start address, sampled on accepted start.
REQ-008 SHALL have port: len  input  8  bytes to read, sampled on accepted start.
REQ-009 SHALL have port: abort  input  1  terminate the current transfer.
REQ-010 SHALL have port: SDIN  input  1  serial data from the selected EEPROM.
REQ-011 SHALL have port: CSf  output  1  chip select, active-low.
REQ-012 SHALL have port: SCLKf  output  1  serial clock.
REQ-013 SHALL have port: SDOUTf  output  1  serial data to EEPROM.
REQ-014 SHALL have port: sel_f  output  2  EEPROM index for the chip-select mux.
REQ-015 SHALL have port: busy  output  1  high from accepted start until done.
REQ-016 SHALL have port: rd_data  output  8  last received byte.
REQ-017 SHALL have port: rd_valid  output  1  one-cycle strobe, rd_data is new.
REQ-018 SHALL have port: done  output  1  one-cycle strobe, transfer ended.

Function
REQ-019 SHALL use SPI mode 0: SCLKf idles low; SDOUTf changes only while SCLKf is low; SDIN is sampled on the clk edge that drives SCLKf high.
REQ-020 SHALL implement states IDLE, SETUP, CMD, ADDR, DATA, HOLD, and return to IDLE.
REQ-021 SHALL accept start only in IDLE with len != 0; accepting it SHALL assert busy, latch dev/addr/len, drive sel_f=dev and CSf=0 on the next cycle, and enter SETUP.
REQ-022 SHALL ignore start while busy, and SHALL ignore start with len == 0 (no CSf activity, no done).
REQ-023 SHALL hold SETUP for CLK_DIV cycles, then enter CMD with SDOUTf = bit 7 of command 0x03.
REQ-024 SHALL shift the command MSB-first in CMD (8 bits), then addr MSB-first in ADDR (ADDR_W bits); SDOUTf SHALL be 0 in DATA.
REQ-025 SHALL keep SCLKf low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
REQ-026 SHALL shift SDIN MSB-first in DATA; on the 8th sample, it SHALL update rd_data and pulse rd_valid for exactly one cycle.
REQ-027 SHALL decrement an 8-bit byte counter per received byte and leave DATA after len bytes, with no SCLKf gap between bytes.
REQ-028 SHALL hold CSf low in HOLD for CLK_DIV cycles after the final SCLKf falling edge, then raise CSf, pulse done, and clear busy in the same cycle.
REQ-029 SHALL, on abort while busy, drive SCLKf low immediately, enter HOLD, and complete as in REQ-028 with no further rd_valid; a partial byte is discarded.
REQ-030 SHALL ignore abort in IDLE; abort and start in the same IDLE cycle SHALL accept the start.
REQ-031 SHALL keep sel_f stable from CSf fall to CSf rise.

Reset
REQ-032 SHALL, while rst_n=0, force CSf=1, SCLKf=0, SDOUTf=0, sel_f=0, busy=0, rd_data=0x00, rd_valid=0, done=0, state=IDLE, counters=0.
REQ-033 SHALL, on reset mid-transfer, raise CSf asynchronously and SHALL NOT emit done.

Verification
REQ-034 SHALL verify a basic read: with CLK_DIV=4, start with dev=2, addr=0x1234, len=3, and a model returning 0xA5,0x3C,0xFF -> sel_f=2, SDOUTf stream 0x03,0x12,0x34, 48 SCLKf rising edges, rd_valid x3 with those bytes, then done.
REQ-035 SHALL verify start while busy: a second start with dev=1 mid-ADDR -> ignored, sel_f stays 2, byte count unchanged.
REQ-036 SHALL verify abort: abort after 10 address bits -> SCLKf low next cycle, CSf high CLK_DIV+1 cycles later, done once, no rd_valid.
REQ-037 SHALL verify len=0: start with len=0 -> CSf stays 1, busy stays 0, no done.
REQ-038 SHALL verify reset mid-transfer: rst_n low during DATA -> CSf=1 and busy=0 immediately; a fresh transfer then reads correct data.
REQ-039 SHALL verify CLK_DIV=2 with len=1 -> SCLKf period of 4 clk cycles, 32 rising edges total.
